dram_host_port: RTL and testbench

//  Host-side master for the external DRAM port of the downsampling CPU. Accepts an input image
//  as a valid/ready byte stream, writes it to DRAM, hands the DRAM to the processor (enable),

---
 rtl/dram_host_port_if.sv | 43 ++++
 rtl/dram_host_port.sv | 212 +++++++++++++++++++++
 tb/tb_dram_host_port.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_host_port_if.sv
// -----------------------------------------------------------------------------
// dram_host_port_if
// Bundles the byte streams and the CPU external DRAM port signals used by
// dram_host_port.
//   master : the host port itself (accepts input stream, produces output
//            stream, drives the DRAM port strobes/address/data)
//   slave  : the environment (stream source/sink, processor DRAM port)
// Signals
//   s_valid/s_data/s_ready  input image byte stream
//   m_valid/m_data/m_ready  result byte stream
//   data_in/add_in          DRAM write data / address
//   data_write/data_read    DRAM strobes
//   selection/enable        DRAM ownership / processor run enable
//   finish/data_out         processor done flag / DRAM read data
// -----------------------------------------------------------------------------
interface dram_host_port_if;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [7:0]  data_in;
    logic [15:0] add_in;
    logic        data_write;
    logic        data_read;
    logic        selection;
    logic        enable;
    logic        finish;
    logic [7:0]  data_out;

    modport master (
        input  s_valid, s_data, m_ready, finish, data_out,
        output s_ready, m_valid, m_data, data_in, add_in,
               data_write, data_read, selection, enable
    );

    modport slave (
        output s_valid, s_data, m_ready, finish, data_out,
        input  s_ready, m_valid, m_data, data_in, add_in,
               data_write, data_read, selection, enable
    );
endinterface

// File: rtl/dram_host_port.sv
// -----------------------------------------------------------------------------
// dram_host_port
// Host-side master for the external DRAM port of the downsampling CPU.
// Sequence per start pulse:
//   LOAD   : stream IN_COUNT bytes into DRAM at IN_BASE.. (16-bit wrap)
//   RUN    : hand DRAM to the processor (selection=1, enable=1), wait finish
//   UNLOAD : read OUT_COUNT bytes from OUT_BASE.. and stream them out
//   FIN    : one-cycle done pulse, back to IDLE
// A RUN phase lasting TIMEOUT cycles aborts with sticky error and a done pulse.
// Ports
//   clka   clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   start  one-cycle start pulse, only honoured in IDLE
//   busy   high in every state except IDLE
//   done   one-cycle pulse at the end of a sequence (normal or aborted)
//   error  sticky RUN timeout flag, cleared by the next accepted start
//   bus    stream + DRAM port bundle (master side)
// All outputs are registered.
// -----------------------------------------------------------------------------
module dram_host_port #(
    parameter logic [15:0] IN_BASE   = 16'h0000,
    parameter int          IN_COUNT  = 65536,
    parameter logic [15:0] OUT_BASE  = 16'h0000,
    parameter int          OUT_COUNT = 16384,
    parameter int          RD_LAT    = 1,
    parameter int          TIMEOUT   = 2**24
) (
    input  logic             clka,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             error,
    dram_host_port_if.master bus
);

    // 17-bit byte counters so a full 65536-byte transfer is representable.
    localparam logic [16:0] IN_TOTAL  = 17'(IN_COUNT);
    localparam logic [16:0] OUT_TOTAL = 17'(OUT_COUNT);
    localparam int          TW        = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] RUN_LAST = TW'(TIMEOUT - 1);
    localparam int          LW        = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [LW-1:0] WAIT_LAST = LW'(RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STOP,
        S_RD,
        S_WAIT,
        S_HOLD,
        S_FIN
    } state_t;

    state_t        state_q;
    logic [16:0]   cnt_q;
    logic [16:0]   cnt_d;
    logic [TW-1:0] run_cnt_q;
    logic [LW-1:0] wait_cnt_q;

    logic          s_ready_q;
    logic          m_valid_q;
    logic [7:0]    m_data_q;
    logic [7:0]    data_in_q;
    logic [15:0]   add_in_q;
    logic          data_write_q;
    logic          data_read_q;
    logic          selection_q;
    logic          enable_q;
    logic          busy_q;
    logic          done_q;
    logic          error_q;

    assign cnt_d = cnt_q + 17'd1;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            run_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            s_ready_q    <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
            data_in_q    <= '0;
            add_in_q     <= '0;
            data_write_q <= 1'b0;
            data_read_q  <= 1'b0;
            selection_q  <= 1'b0;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // Strobes and done are single-cycle pulses unless re-armed below.
            data_write_q <= 1'b0;
            data_read_q  <= 1'b0;
            done_q       <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_LOAD;
                        cnt_q     <= '0;
                        error_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        s_ready_q <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (cnt_q == IN_TOTAL) begin
                        // Last write strobe has just completed with selection=0;
                        // only now hand the DRAM over.
                        selection_q <= 1'b1;
                        enable_q    <= 1'b1;
                        run_cnt_q   <= '0;
                        state_q     <= S_RUN;
                    end else if (bus.s_valid && s_ready_q) begin
                        data_in_q    <= bus.s_data;
                        add_in_q     <= IN_BASE + cnt_q[15:0];
                        data_write_q <= 1'b1;
                        cnt_q        <= cnt_d;
                        if (cnt_d == IN_TOTAL) begin
                            s_ready_q <= 1'b0;
                        end
                    end
                end

                S_RUN: begin
                    run_cnt_q <= run_cnt_q + TW'(1);
                    // finish in the first RUN cycle may be left over from a
                    // previous job, so it is only honoured from cycle two.
                    if ((run_cnt_q != '0) && bus.finish) begin
                        enable_q <= 1'b0;
                        state_q  <= S_STOP;
                    end else if (run_cnt_q == RUN_LAST) begin
                        enable_q    <= 1'b0;
                        selection_q <= 1'b0;
                        error_q     <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= S_FIN;
                    end
                end

                S_STOP: begin
                    // Processor disabled one cycle ago; reclaim the port and
                    // issue the first read on the same edge.
                    selection_q <= 1'b0;
                    cnt_q       <= '0;
                    add_in_q    <= OUT_BASE;
                    data_read_q <= 1'b1;
                    state_q     <= S_RD;
                end

                S_RD: begin
                    wait_cnt_q <= '0;
                    state_q    <= S_WAIT;
                end

                S_WAIT: begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        m_data_q  <= bus.data_out;
                        m_valid_q <= 1'b1;
                        state_q   <= S_HOLD;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + LW'(1);
                    end
                end

                S_HOLD: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        cnt_q     <= cnt_d;
                        if (cnt_d == OUT_TOTAL) begin
                            done_q  <= 1'b1;
                            state_q <= S_FIN;
                        end else begin
                            add_in_q    <= OUT_BASE + cnt_d[15:0];
                            data_read_q <= 1'b1;
                            state_q     <= S_RD;
                        end
                    end
                end

                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign bus.s_ready    = s_ready_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.m_data     = m_data_q;
    assign bus.data_in    = data_in_q;
    assign bus.add_in     = add_in_q;
    assign bus.data_write = data_write_q;
    assign bus.data_read  = data_read_q;
    assign bus.selection  = selection_q;
    assign bus.enable     = enable_q;

endmodule

// File: tb/tb_dram_host_port.sv
// -----------------------------------------------------------------------------
// tb_dram_host_port
// Directed bench for dram_host_port. Two instances:
//   A: IN_BASE=0x0010 IN_COUNT=4 OUT_BASE=0xC000 OUT_COUNT=3 RD_LAT=2
//   B: IN_BASE=0xFFFE IN_COUNT=4 TIMEOUT=100 (processor never finishes)
// -----------------------------------------------------------------------------
module tb_dram_host_port;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, start_a, busy_a, done_a, error_a;
    logic rst_b_n, start_b, busy_b, done_b, error_b;

    dram_host_port_if bus_a ();
    dram_host_port_if bus_b ();

    dram_host_port #(
        .IN_BASE  (16'h0010),
        .IN_COUNT (4),
        .OUT_BASE (16'hC000),
        .OUT_COUNT(3),
        .RD_LAT   (2),
        .TIMEOUT  (1000)
    ) dut_a (
        .clka (clk),
        .rst_n(rst_a_n),
        .start(start_a),
        .busy (busy_a),
        .done (done_a),
        .error(error_a),
        .bus  (bus_a)
    );

    dram_host_port #(
        .IN_BASE  (16'hFFFE),
        .IN_COUNT (4),
        .OUT_BASE (16'h0000),
        .OUT_COUNT(2),
        .RD_LAT   (1),
        .TIMEOUT  (100)
    ) dut_b (
        .clka (clk),
        .rst_n(rst_b_n),
        .start(start_b),
        .busy (busy_b),
        .done (done_b),
        .error(error_b),
        .bus  (bus_b)
    );

    int total = 0;
    int bad   = 0;
    int wr_cnt_a = 0, rd_cnt_a = 0, done_cnt_a = 0;
    int wr_cnt_b = 0, rd_cnt_b = 0, done_cnt_b = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DRAM contents for the result region of instance A.
    function automatic logic [7:0] dram_a(input logic [15:0] addr);
        case (addr)
            16'hC000: dram_a = 8'h55;
            16'hC001: dram_a = 8'h66;
            16'hC002: dram_a = 8'h77;
            default:  dram_a = 8'hEE;
        endcase
    endfunction

    // Two-stage read pipe: data valid exactly RD_LAT=2 cycles after data_read.
    logic [7:0] rd_pipe_a = 8'h00;
    always @(posedge clk) begin
        rd_pipe_a      <= bus_a.data_read ? dram_a(bus_a.add_in) : 8'h00;
        bus_a.data_out <= rd_pipe_a;
    end

    // Bus monitors: one line per transaction plus port-protocol checks.
    always @(negedge clk) begin
        if (bus_a.data_write || bus_a.data_read)
            chk("a_strobe_excl", 32'({bus_a.data_write & bus_a.data_read, bus_a.selection}), 32'd0);
        if (bus_a.data_write) begin
            wr_cnt_a++;
            $display("A write addr=%h data=%h", bus_a.add_in, bus_a.data_in);
        end
        if (bus_a.data_read) begin
            rd_cnt_a++;
            $display("A read  addr=%h", bus_a.add_in);
        end
        if (bus_a.m_valid && bus_a.m_ready)
            $display("A out   data=%h", bus_a.m_data);
        if (done_a) done_cnt_a++;

        if (bus_b.data_write || bus_b.data_read)
            chk("b_strobe_excl", 32'({bus_b.data_write & bus_b.data_read, bus_b.selection}), 32'd0);
        if (bus_b.data_write) begin
            wr_cnt_b++;
            $display("B write addr=%h data=%h", bus_b.add_in, bus_b.data_in);
        end
        if (bus_b.data_read) begin
            rd_cnt_b++;
            $display("B read  addr=%h", bus_b.add_in);
        end
        if (done_b) done_cnt_b++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [7:0]  t2_bytes [4];
    int          t2_gap   [4];
    logic [7:0]  t4_exp   [3];
    logic [15:0] t5_addr  [4];
    int          wr_base;
    int          k;

    initial begin
        t2_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        t2_gap   = '{0, 2, 1, 3};
        t4_exp   = '{8'h55, 8'h66, 8'h77};
        t5_addr  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};

        rst_a_n = 1'b0; rst_b_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        bus_a.s_valid = 1'b0; bus_a.s_data = 8'h00; bus_a.m_ready = 1'b0; bus_a.finish = 1'b0;
        bus_b.s_valid = 1'b0; bus_b.s_data = 8'h00; bus_b.m_ready = 1'b0; bus_b.finish = 1'b0;
        bus_b.data_out = 8'h00;
        repeat (3) tick();

        // Reset state
        chk("rst_busy_a",   32'(busy_a), 32'd0);
        chk("rst_sready_a", 32'(bus_a.s_ready), 32'd0);
        chk("rst_mvalid_a", 32'(bus_a.m_valid), 32'd0);
        chk("rst_sel_a",    32'(bus_a.selection), 32'd0);
        chk("rst_en_a",     32'(bus_a.enable), 32'd0);
        chk("rst_addr_a",   32'(bus_a.add_in), 32'd0);
        chk("rst_err_b",    32'(error_b), 32'd0);
        chk("rst_done_b",   32'(done_b), 32'd0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        tick();

        // T1: reset in the middle of LOAD
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("t1_busy",   32'(busy_a), 32'd1);
        chk("t1_sready", 32'(bus_a.s_ready), 32'd1);
        bus_a.s_valid = 1'b1; bus_a.s_data = 8'h11; tick();
        bus_a.s_data = 8'h22; tick();
        bus_a.s_valid = 1'b0;
        chk("t1_wr",     32'(bus_a.data_write), 32'd1);
        chk("t1_addr",   32'(bus_a.add_in), 32'h11);
        #2 rst_a_n = 1'b0;
        #1;
        chk("t1_async_busy",  32'(busy_a), 32'd0);
        chk("t1_async_sready",32'(bus_a.s_ready), 32'd0);
        chk("t1_async_wr",    32'(bus_a.data_write), 32'd0);
        chk("t1_async_addr",  32'(bus_a.add_in), 32'd0);
        chk("t1_async_data",  32'(bus_a.data_in), 32'd0);
        tick();
        rst_a_n = 1'b1;
        repeat (3) tick();
        chk("t1_idle_busy", 32'(busy_a), 32'd0);
        chk("t1_no_done",   32'(done_cnt_a), 32'd0);

        // T2: load with gaps in s_valid
        wr_base = wr_cnt_a;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("t2_sready", 32'(bus_a.s_ready), 32'd1);
        chk("t2_err",    32'(error_a), 32'd0);
        bus_a.finish = 1'b1;  // stale finish, must be ignored on RUN entry
        for (int i = 0; i < 4; i++) begin
            bus_a.s_valid = 1'b0;
            repeat (t2_gap[i]) begin
                tick();
                chk("t2_no_wr_gap", 32'(bus_a.data_write), 32'd0);
            end
            bus_a.s_valid = 1'b1; bus_a.s_data = t2_bytes[i];
            tick();
            bus_a.s_valid = 1'b0;
            chk("t2_wr",     32'(bus_a.data_write), 32'd1);
            chk("t2_addr",   32'(bus_a.add_in), 32'(16'h0010 + 16'(i)));
            chk("t2_data",   32'(bus_a.data_in), 32'(t2_bytes[i]));
            chk("t2_sready_after", 32'(bus_a.s_ready), (i == 3) ? 32'd0 : 32'd1);
            chk("t2_sel_load", 32'(bus_a.selection), 32'd0);
        end
        tick();
        chk("t2_wr_end",  32'(bus_a.data_write), 32'd0);
        chk("t2_sel_run", 32'(bus_a.selection), 32'd1);
        chk("t2_en_run",  32'(bus_a.enable), 32'd1);
        chk("t2_wr_count", 32'(wr_cnt_a - wr_base), 32'd4);

        // T3: stale finish ignored, then real finish after ~50 cycles
        tick();
        chk("t3_stale_finish", 32'(bus_a.enable), 32'd1);
        bus_a.finish = 1'b0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        chk("t3_start_ignored_en", 32'(bus_a.enable), 32'd1);
        chk("t3_start_ignored_sr", 32'(bus_a.s_ready), 32'd0);
        repeat (48) tick();
        chk("t3_still_run", 32'(bus_a.enable), 32'd1);
        bus_a.finish = 1'b1;
        tick();
        chk("t3_en_off",   32'(bus_a.enable), 32'd0);
        chk("t3_sel_held", 32'(bus_a.selection), 32'd1);
        bus_a.finish = 1'b0;
        tick();
        chk("t3_sel_off",  32'(bus_a.selection), 32'd0);
        chk("t3_rd0",      32'(bus_a.data_read), 32'd1);
        chk("t3_rd0_addr", 32'(bus_a.add_in), 32'hC000);

        // T4: unload with backpressure on byte 2
        for (int i = 0; i < 3; i++) begin
            k = 0;
            while (!bus_a.m_valid && k < 20) begin
                tick();
                k++;
            end
            chk("t4_mvalid",  32'(bus_a.m_valid), 32'd1);
            chk("t4_latency", 32'(k), 32'd3);
            chk("t4_data",    32'(bus_a.m_data), 32'(t4_exp[i]));
            if (i == 1) begin
                repeat (5) begin
                    tick();
                    chk("t4_hold_valid", 32'(bus_a.m_valid), 32'd1);
                    chk("t4_hold_data",  32'(bus_a.m_data), 32'h66);
                    chk("t4_hold_no_rd", 32'(bus_a.data_read), 32'd0);
                end
            end
            bus_a.m_ready = 1'b1;
            tick();
            bus_a.m_ready = 1'b0;
            chk("t4_mvalid_drop", 32'(bus_a.m_valid), 32'd0);
            chk("t4_done", 32'(done_a), (i == 2) ? 32'd1 : 32'd0);
            if (i < 2) begin
                chk("t4_next_rd",   32'(bus_a.data_read), 32'd1);
                chk("t4_next_addr", 32'(bus_a.add_in), 32'(16'hC001 + 16'(i)));
            end
        end
        tick();
        chk("t4_done_end",  32'(done_a), 32'd0);
        chk("t4_idle_busy", 32'(busy_a), 32'd0);
        chk("t4_rd_count",  32'(rd_cnt_a), 32'd3);
        chk("t4_done_count",32'(done_cnt_a), 32'd1);

        // T5: address wrap on instance B, continuous stream
        start_b = 1'b1; tick(); start_b = 1'b0;
        bus_b.s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_b.s_data = 8'hE0 + 8'(i);
            tick();
            chk("t5_wr",   32'(bus_b.data_write), 32'd1);
            chk("t5_addr", 32'(bus_b.add_in), 32'(t5_addr[i]));
            chk("t5_data", 32'(bus_b.data_in), 32'(8'hE0 + 8'(i)));
        end
        bus_b.s_valid = 1'b0;
        chk("t5_sready_off", 32'(bus_b.s_ready), 32'd0);
        tick();
        chk("t5_sel_run", 32'(bus_b.selection), 32'd1);
        chk("t5_wr_count", 32'(wr_cnt_b), 32'd4);

        // T6: RUN timeout at cycle 100
        repeat (99) tick();
        chk("t6_err_early", 32'(error_b), 32'd0);
        chk("t6_sel_early", 32'(bus_b.selection), 32'd1);
        tick();
        chk("t6_err",  32'(error_b), 32'd1);
        chk("t6_sel",  32'(bus_b.selection), 32'd0);
        chk("t6_en",   32'(bus_b.enable), 32'd0);
        chk("t6_done", 32'(done_b), 32'd1);
        tick();
        chk("t6_done_end", 32'(done_b), 32'd0);
        chk("t6_idle",     32'(busy_b), 32'd0);
        repeat (2) tick();
        chk("t6_err_sticky", 32'(error_b), 32'd1);
        chk("t6_no_read",    32'(rd_cnt_b), 32'd0);
        chk("t6_done_count", 32'(done_cnt_b), 32'd1);
        start_b = 1'b1; tick(); start_b = 1'b0;
        chk("t6_err_clear", 32'(error_b), 32'd0);
        chk("t6_restart",   32'(busy_b), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
